// File: rtl/atm_teclado.sv
// ATM keypad front end: synchronizes and debounces a single key line, then
// routes accepted keys either to PIN digit output or to a decimal amount accumulator.
module atm_teclado #(
  parameter int DEB_CYC = 4,
  parameter int MAX_DIG = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tecla_raw,
  input  logic [3:0]  tecla_cod,
  input  logic        modo,
  output logic [3:0]  digito,
  output logic        digito_stb,
  output logic [31:0] monto,
  output logic        monto_stb,
  output logic        monto_error,
  output logic        captura
);

  typedef enum logic [1:0] {LIBRE, VAL_PRESS, PULSADA, VAL_SUELTA} deb_state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYC - 1);
  localparam logic [7:0] MAX_CNT  = 8'(MAX_DIG);

  logic       sync1, tsync;
  deb_state_t state, state_next;
  logic [7:0] deb_cnt, deb_cnt_next;
  logic       accept;

  logic        modo_q;
  logic [31:0] acc, acc_next;
  logic [7:0]  count, count_next;
  logic [3:0]  digito_next;
  logic [31:0] monto_next;
  logic        dig_stb_next, mon_stb_next, err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      tsync <= 1'b0;
    end else begin
      sync1 <= tecla_raw;
      tsync <= sync1;
    end
  end

  // Reset parks in VAL_SUELTA so a key held through reset must be released first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= VAL_SUELTA;
      deb_cnt <= 8'd0;
    end else begin
      state   <= state_next;
      deb_cnt <= deb_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    deb_cnt_next = deb_cnt;
    accept       = 1'b0;
    case (state)
      LIBRE: begin
        if (tsync) begin
          state_next   = VAL_PRESS;
          deb_cnt_next = 8'd0;
        end
      end
      VAL_PRESS: begin
        if (!tsync) begin
          state_next   = LIBRE;
          deb_cnt_next = 8'd0;
        end else if (deb_cnt == DEB_LAST) begin
          accept       = 1'b1;
          state_next   = PULSADA;
          deb_cnt_next = 8'd0;
        end else begin
          deb_cnt_next = deb_cnt + 8'd1;
        end
      end
      PULSADA: begin
        if (!tsync) begin
          state_next   = VAL_SUELTA;
          deb_cnt_next = 8'd0;
        end
      end
      VAL_SUELTA: begin
        if (tsync) begin
          state_next   = PULSADA;
          deb_cnt_next = 8'd0;
        end else if (deb_cnt == DEB_LAST) begin
          state_next   = LIBRE;
          deb_cnt_next = 8'd0;
        end else begin
          deb_cnt_next = deb_cnt + 8'd1;
        end
      end
      default: begin
        state_next   = VAL_SUELTA;
        deb_cnt_next = 8'd0;
      end
    endcase
  end

  // A mode switch discards any partial amount, taking priority over a key in the same cycle.
  always_comb begin
    acc_next     = acc;
    count_next   = count;
    digito_next  = digito;
    monto_next   = monto;
    dig_stb_next = 1'b0;
    mon_stb_next = 1'b0;
    err_next     = 1'b0;
    if (modo != modo_q) begin
      acc_next   = 32'd0;
      count_next = 8'd0;
    end else if (accept) begin
      if (!modo) begin
        if (tecla_cod <= 4'd9) begin
          digito_next  = tecla_cod;
          dig_stb_next = 1'b1;
        end
      end else if (tecla_cod <= 4'd9) begin
        if (count == MAX_CNT) begin
          err_next   = 1'b1;
          acc_next   = 32'd0;
          count_next = 8'd0;
        end else begin
          acc_next   = acc * 32'd10 + 32'(tecla_cod);
          count_next = count + 8'd1;
        end
      end else if (tecla_cod == 4'hA) begin
        if (count != 8'd0) begin
          monto_next   = acc;
          mon_stb_next = 1'b1;
          acc_next     = 32'd0;
          count_next   = 8'd0;
        end
      end else if (tecla_cod == 4'hB) begin
        acc_next   = 32'd0;
        count_next = 8'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      modo_q      <= 1'b0;
      acc         <= 32'd0;
      count       <= 8'd0;
      digito      <= 4'd0;
      monto       <= 32'd0;
      digito_stb  <= 1'b0;
      monto_stb   <= 1'b0;
      monto_error <= 1'b0;
      captura     <= 1'b0;
    end else begin
      modo_q      <= modo;
      acc         <= acc_next;
      count       <= count_next;
      digito      <= digito_next;
      monto       <= monto_next;
      digito_stb  <= dig_stb_next;
      monto_stb   <= mon_stb_next;
      monto_error <= err_next;
      captura     <= (count_next != 8'd0);
    end
  end

endmodule
